// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync + per-channel debounce filter, phase tracking FSM.
// Step strobe lands FiltLen+2 edges after first sample; no backpressure, steps faster than the filter are dropped.

module quad_decoder_chan #(
  parameter int FiltLen = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic raw_i,
  output logic sync_o,
  output logic lvl_o
);

  localparam int CntW = $clog2(FiltLen + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FiltLen - 1);

  logic            s1;
  logic            s2;
  logic [CntW-1:0] cnt;

  assign sync_o = s2;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl_o <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw_i;
      s2 <= s1;
      if (load_i) begin
        lvl_o <= s2;
        cnt   <= '0;
      end else if (s2 == lvl_o) begin
        cnt <= '0;
      end else if (cnt == CntLast) begin
        // FiltLen-th consecutive disagreeing cycle: accept the new level
        lvl_o <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

endmodule

module quad_decoder #(
  parameter int FiltLen = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_i,
  input  logic b_i,
  input  logic clr_err_i,
  output logic en_o,
  output logic up_o,
  output logic err_o,
  output logic err_sticky_o
);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  state_t     state;
  logic [1:0] init_cnt;
  logic [1:0] phase;
  logic [1:0] sync_phase;
  logic [1:0] prev;
  logic [1:0] delta;
  logic       load;
  logic       step_vld;
  logic       err_vld;
  logic       up_nxt;

  assign load = (state == INIT);

  quad_decoder_chan #(.FiltLen(FiltLen)) u_chan_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .raw_i  (a_i),
    .sync_o (sync_phase[1]),
    .lvl_o  (phase[1])
  );

  quad_decoder_chan #(.FiltLen(FiltLen)) u_chan_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .raw_i  (b_i),
    .sync_o (sync_phase[0]),
    .lvl_o  (phase[0])
  );

  assign delta    = phase ^ prev;
  assign step_vld = (state == TRACK) && (delta == 2'b01 || delta == 2'b10);
  assign err_vld  = (state == TRACK) && (delta == 2'b11);
  // Forward order 00->10->11->01: an A move lands on A!=B, a B move lands on A==B
  assign up_nxt   = delta[1] ? (phase[1] ^ phase[0]) : ~(phase[1] ^ phase[0]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= INIT;
      init_cnt     <= 2'd0;
      prev         <= 2'b00;
      en_o         <= 1'b0;
      up_o         <= 1'b1;
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
    end else begin
      en_o  <= step_vld;
      err_o <= err_vld;
      if (step_vld) begin
        up_o <= up_nxt;
      end
      if (err_vld) begin
        err_sticky_o <= 1'b1;
      end else if (clr_err_i) begin
        err_sticky_o <= 1'b0;
      end
      case (state)
        INIT: begin
          // Track the same value the filters load so TRACK starts with no delta
          prev     <= sync_phase;
          init_cnt <= init_cnt + 2'd1;
          if (init_cnt == 2'd2) begin
            state <= TRACK;
          end
        end
        TRACK: begin
          prev <= phase;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  a_no_en_and_err : assert property (@(posedge clk_i) disable iff (!rst_ni) !(en_o && err_o));
  a_en_single     : assert property (@(posedge clk_i) disable iff (!rst_ni) en_o |=> !en_o);

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: directed edges push expected strobes, monitor checks them on negedge.
module tb_quad_decoder;

  localparam int FL = 4;

  typedef struct {
    logic is_err;
    logic up;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic a_i;
  logic b_i;
  logic clr_err_i;
  logic en_o;
  logic up_o;
  logic err_o;
  logic err_sticky_o;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic rst_q = 1'b0;
  bit   mon_en = 1'b0;
  logic exp_up_now = 1'b1;
  exp_t q[$];
  exp_t mon_e;

  quad_decoder #(.FiltLen(FL)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .a_i          (a_i),
    .b_i          (b_i),
    .clr_err_i    (clr_err_i),
    .en_o         (en_o),
    .up_o         (up_o),
    .err_o        (err_o),
    .err_sticky_o (err_sticky_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_ni;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic is_err, input logic up, input int c);
    exp_t e;
    e.is_err = is_err;
    e.up     = up;
    e.cyc    = c;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Change the phase at a negedge, expect a strobe FL+3 cycles later, then settle
  task automatic drive(input logic av, input logic bv, input logic is_err, input logic up);
    @(negedge clk);
    a_i = av;
    b_i = bv;
    push(is_err, up, cyc + FL + 3);
    repeat (9) @(negedge clk);
  endtask

  task automatic do_reset(input logic av, input logic bv);
    @(negedge clk);
    rst_ni = 1'b0;
    a_i    = av;
    b_i    = bv;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the queue at its cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_q) begin
        exp_up_now = 1'b1;
      end else begin
        if (q.size() > 0 && cyc > q[0].cyc) begin
          chk("missed_output_cyc", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        if (en_o || err_o) begin
          chk("output_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("output_cyc", cyc, mon_e.cyc);
            chk("err_o", int'(err_o), int'(mon_e.is_err));
            chk("en_o", int'(en_o), int'(!mon_e.is_err));
            if (!mon_e.is_err) begin
              chk("up_o_step", int'(up_o), int'(mon_e.up));
              exp_up_now = mon_e.up;
            end else begin
              chk("up_o_on_err", int'(up_o), int'(exp_up_now));
            end
          end
        end else begin
          chk("up_o_hold", int'(up_o), int'(exp_up_now));
        end
      end
    end
  end

  initial begin
    int n;
    rst_ni    = 1'b0;
    a_i       = 1'b1;
    b_i       = 1'b1;
    clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en_o", int'(en_o), 0);
    chk("rst_up_o", int'(up_o), 1);
    chk("rst_err_o", int'(err_o), 0);
    chk("rst_err_sticky_o", int'(err_sticky_o), 0);
    mon_en = 1'b1;
    rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle11_err_sticky_o", int'(err_sticky_o), 0);

    do_reset(1'b0, 1'b0);
    // forward 00->10->11->01->00
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    // reverse 00->01->11->10, then forward 10->11
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    // back to 00 going forward
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // 3-cycle glitch: filtered out
    @(negedge clk);
    a_i = 1'b1;
    repeat (3) @(negedge clk);
    a_i = 1'b0;
    repeat (12) @(negedge clk);
    // 4-cycle pulse: one up step, and the held return gives one down step
    n = cyc;
    a_i = 1'b1;
    push(1'b0, 1'b1, n + FL + 3);
    wait_cyc(n + 4);
    a_i = 1'b0;
    push(1'b0, 1'b0, n + 4 + FL + 3);
    repeat (15) @(negedge clk);

    // simultaneous A/B change 00->11
    n = cyc;
    a_i = 1'b1;
    b_i = 1'b1;
    push(1'b1, 1'b0, n + FL + 3);
    wait_cyc(n + FL + 3);
    chk("sticky_set", int'(err_sticky_o), 1);
    clr_err_i = 1'b1;
    wait_cyc(n + FL + 4);
    chk("sticky_cleared", int'(err_sticky_o), 0);
    clr_err_i = 1'b0;
    repeat (8) @(negedge clk);

    // error 11->00 coincident with clear: set wins
    n = cyc;
    a_i = 1'b0;
    b_i = 1'b0;
    push(1'b1, 1'b0, n + FL + 3);
    wait_cyc(n + FL + 2);
    clr_err_i = 1'b1;
    wait_cyc(n + FL + 3);
    chk("sticky_set_wins", int'(err_sticky_o), 1);
    clr_err_i = 1'b0;
    wait_cyc(n + FL + 4);
    chk("sticky_held", int'(err_sticky_o), 1);
    repeat (8) @(negedge clk);

    // reset two counts into a pending A edge
    n = cyc;
    a_i = 1'b1;
    wait_cyc(n + 4);
    rst_ni = 1'b0;
    wait_cyc(n + 5);
    chk("midrst_en_o", int'(en_o), 0);
    chk("midrst_up_o", int'(up_o), 1);
    chk("midrst_err_o", int'(err_o), 0);
    chk("midrst_err_sticky_o", int'(err_sticky_o), 0);
    wait_cyc(n + 6);
    rst_ni = 1'b1;
    repeat (15) @(negedge clk);
    // adopted phase 10; 10->11 is a forward step
    drive(1'b1, 1'b1, 1'b0, 1'b1);

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
